// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder slice per clock, LSB first (optional subtract via SERIAL_ADDER_SUB_EN)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d, b_load;
  logic c_q, c_d, carry_q, carry_d, done_q, done_d, c_load;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fa_s, fa_c, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub | cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif
  assign fa_s  = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_c  = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign last  = cnt_q == CW'(WIDTH - 1);
  assign busy  = state_q == RUN;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;
  // state and datapath registers, cleared asynchronously so reset aborts a run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end
  // capture on start in IDLE, otherwise shift one bit through the slice; publish result on the last bit
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        a_d     = a;
        b_d     = b_load;
        c_d     = c_load;
        cnt_d   = '0;
        state_d = RUN;
      end
    end else begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = fa_c;
      s_d   = {fa_s, s_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        sum_d   = {fa_s, s_q[WIDTH-1:1]};
        carry_d = fa_c;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against an arithmetic reference
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, start = 0, cin = 0, sub = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, carry;
  logic [W-1:0] exp_sum = '0;
  logic exp_carry = 0;
  int checks = 0, errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // called at a negedge: drives start, runs to the done negedge and leaves time there
  task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc, input logic os);
    logic [W:0] r;
    if (os) r = {oa >= ob, W'(oa - ob)};
    else r = {1'b0, oa} + {1'b0, ob} + (W+1)'(oc);
    a = oa; b = ob; cin = oc; sub = os; start = 1;
    @(negedge clk);
    for (int i = 0; i < W; i++) begin
      start = 1'($urandom);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("sum_held", sum, exp_sum);
      chk("carry_held", carry, exp_carry);
      @(negedge clk);
    end
    start = 0;
    exp_sum = r[W-1:0];
    exp_carry = r[W];
    chk("done_pulse", done, 1);
    chk("busy_fall", busy, 0);
    chk("sum", sum, exp_sum);
    chk("carry", carry, exp_carry);
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    chk("sum_keep", sum, exp_sum);
    chk("carry_keep", carry, exp_carry);
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    op(8'h3C, 8'h0F, 0, 0); chk("basic", sum, 8'h4B); after_done();
    repeat (3) begin @(negedge clk); chk("idle_hold", sum, 8'h4B); end
    @(negedge clk); op(8'hFF, 8'h01, 0, 0); chk("c1", {carry, sum}, 9'h100); after_done();
    @(negedge clk); op(8'hFF, 8'hFF, 1, 0); chk("c2", {carry, sum}, 9'h1FF); after_done();
    @(negedge clk); op(8'h00, 8'h00, 1, 0); chk("c3", {carry, sum}, 9'h001); after_done();
    @(negedge clk); op(8'h11, 8'h22, 0, 0);
    op(8'h10, 8'h20, 0, 0); chk("b2b", sum, 8'h30); after_done();
    // reset while idle with a nonzero result held
    @(negedge clk); op(8'hA5, 8'h5A, 1, 0); after_done();
    #2 rst_n = 0; #1;
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_sum", sum, 0);
    chk("rst2_carry", carry, 0);
    exp_sum = '0; exp_carry = 0;
    @(negedge clk); rst_n = 1;
    // abort mid-run
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1; sub = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    rst_n = 0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    op(8'h01, 8'h02, 0, 0); chk("post_abort", {carry, sum}, 9'h003); after_done();
`ifdef SERIAL_ADDER_SUB_EN
    @(negedge clk); op(8'h05, 8'h07, 0, 1); chk("sub1", {carry, sum}, 9'h0FE); after_done();
    @(negedge clk); op(8'h07, 8'h05, 1, 1); chk("sub2", {carry, sum}, 9'h102); after_done();
`endif
    for (int n = 0; n < 20; n++) begin
      logic os;
`ifdef SERIAL_ADDER_SUB_EN
      os = 1'($urandom);
`else
      os = 0;
`endif
      if (n % 2 == 0) @(negedge clk);
      op(W'($urandom), W'($urandom), 1'($urandom), os);
    end
    after_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder: the sequential successor to the combinational half/full-adder cells. It accepts two WIDTH-bit operands plus carry-in on a start strobe. It then resolves one bit per clock, LSB first, through a single full-adder slice with a registered carry, and presents a held sum/carry with a one-cycle done pulse. It is intended for area-constrained datapaths where a WIDTH-bit ripple adder is not affordable.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only when idle.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high while the computation is in progress.
- done  out  1  one-cycle pulse: result updated.
- sum  out  WIDTH  registered result; held until the next completion.
- carry  out  1  registered carry-out; held with sum.

## Operation
- States:
  - IDLE: reset state; start accepted.
  - RUN: one bit processed per cycle.
- Internal registers:
  - a_sh, b_sh: WIDTH-bit operand shift registers.
  - c: 1-bit carry register.
  - s_sh: WIDTH-bit sum shift register.
  - cnt: bit counter, width $clog2(WIDTH)+1.
- IDLE & start=1: a_sh<=a, b_sh<=b, c<=cin, cnt<=0, go to RUN.
- IDLE & start=0: hold all registers.
- RUN, every edge:
  - bit = a_sh[0]^b_sh[0]^c.
  - c <= majority(a_sh[0], b_sh[0], c).
  - a_sh and b_sh shift right by one.
  - s_sh <= {bit, s_sh[WIDTH-1:1]}.
  - cnt <= cnt+1.
- RUN final edge (cnt==WIDTH-1):
  - sum <= {bit, s_sh[WIDTH-1:1]}.
  - carry <= majority of the final bits.
  - done <= 1; go to IDLE.
- done is registered and cleared on the following edge.
- sum and carry change only on the completion edge; they hold the previous result throughout RUN.
- start while in RUN is ignored. It is not queued.
- Arithmetic: {carry,sum} = a + b + cin, exact, modulo 2^(WIDTH+1). No overflow flag.

## Timing
- Reset (rst_n low, any time, asynchronous): state=IDLE, busy=0, done=0, sum=0, carry=0; internal shift registers, c and cnt also 0.
- Reset mid-RUN aborts the operation immediately. No done is produced.
- A start accepted on edge E0 gives:
  - busy=1 from E0 to E(WIDTH).
  - done=1 and the new sum/carry from E(WIDTH) to E(WIDTH+1).
  - Latency is WIDTH cycles, start edge to result.
- busy = (state==RUN). It falls on the same edge where done rises.
- Start is accepted in the done-high cycle, because the state is already IDLE. This allows back-to-back operations with a throughput of one result per WIDTH+1 cycles.
- start held high continuously re-launches on every IDLE cycle.
- a, b and cin may change freely after the accepting edge.

## Configuration
- SERIAL_ADDER_SUB_EN:
  - Defined: adds port "sub  in  1", captured with start.
    - sub=1: b_sh<=~b and c<=1; cin is ignored.
    - Result: sum = a - b mod 2^WIDTH; carry=1 means no borrow (a>=b, unsigned).
    - sub=0: behaviour identical to the add-only build.
  - Not defined: the sub port is absent and the block is add-only.

## Test plan
- Reset: drive rst_n=0 mid-simulation -> same cycle: busy=0, done=0, sum=8'h00, carry=0.
- Basic add, WIDTH=8: a=8'h3C, b=8'h0F, cin=0, start for 1 cycle -> busy high for exactly 8 cycles; done high for exactly 1 cycle; sum=8'h4B, carry=0, held afterwards.
- Carry corners:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, carry=1.
  - a=8'h00, b=8'h00, cin=1 -> sum=8'h01, carry=0.
- Handshake:
  - Start pulses during RUN -> ignored; exactly one done.
  - Start in the done cycle with a=8'h10, b=8'h20 -> second done 9 cycles after the first, sum=8'h30.
  - The first result is held until the second done.
- Abort: rst_n low at RUN cycle 4, release, then issue a=8'h01, b=8'h02 -> no done from the aborted operation; the next result is sum=8'h03, carry=0.
- SERIAL_ADDER_SUB_EN:
  - sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, carry=0.
  - sub=1, a=8'h07, b=8'h05 -> sum=8'h02, carry=1.
